// File: rtl/cpu_sequencer.sv
// Instruction-phase sequencer for an 8-phase accumulator CPU: IDLE/RUN/HALTED FSM plus datapath controls.
// Define STEP_EN to add single-step support (step_mode/step inputs and a PAUSED state).
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       zero,
  input  logic [2:0] opcode,
`ifdef STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic       busy,
  output logic [7:0] instr_cnt
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

`ifdef STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_PAUSED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
`endif

  state_t     state, state_next;
  logic [2:0] phase_next;
  logic [7:0] cnt_next;
  logic       alu;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      instr_cnt <= '0;
    end else begin
      state     <= state_next;
      phase     <= phase_next;
      instr_cnt <= cnt_next;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    phase_next = phase;
    cnt_next   = instr_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          phase_next = 3'd0;
        end
      end
      S_RUN: begin
        if (phase == 3'd4 && opcode == OP_HLT) begin
          state_next = S_HALTED;  // phase stays frozen at 4
        end else begin
          phase_next = phase + 3'd1;
          if (phase == 3'd7) begin
            cnt_next = instr_cnt + 8'd1;
`ifdef STEP_EN
            if (step_mode) state_next = S_PAUSED;
`endif
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          state_next = S_RUN;
          phase_next = 3'd5;
        end
      end
`ifdef STEP_EN
      S_PAUSED: begin
        if (step || !step_mode) state_next = S_RUN;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign alu  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                (opcode == OP_XOR) || (opcode == OP_LDA);
  assign busy = (state == S_RUN);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (state == S_RUN) begin
      case (phase)
        3'd0: sel = 1'b1;
        3'd1: begin sel = 1'b1; rd = 1'b1; end
        3'd2, 3'd3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        3'd4: begin inc_pc = 1'b1; halt = (opcode == OP_HLT); end
        3'd5: rd = alu;
        3'd6: begin
          rd     = alu;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        default: begin
          rd     = alu;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          ld_ac  = alu;
          wr     = (opcode == OP_STO);
        end
      endcase
    end else if (state == S_HALTED) begin
      halt = 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of per-opcode control patterns plus
// hand-written halt/resume, mid-instruction reset, counter wrap and (with STEP_EN) single-step sequences.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, zero;
  logic [2:0] opcode;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, busy;
  logic [7:0] instr_cnt;
  logic [8:0] ctrl;
`ifdef STEP_EN
  logic       step_mode, step;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .zero      (zero),
    .opcode    (opcode),
`ifdef STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .phase     (phase),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .halt      (halt),
    .ld_pc     (ld_pc),
    .data_e    (data_e),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .busy      (busy),
    .instr_cnt (instr_cnt)
  );

  // Control bundle order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  assign ctrl = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  typedef struct {
    string           name;
    logic [2:0]      op;
    logic            z;
    logic [7:0][8:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(string name, logic [2:0] op, logic z,
                              logic [8:0] c5, logic [8:0] c6, logic [8:0] c7);
    vec_t v;
    v.name   = name;
    v.op     = op;
    v.z      = z;
    v.exp[0] = 9'b100000000;
    v.exp[1] = 9'b110000000;
    v.exp[2] = 9'b111000000;
    v.exp[3] = 9'b111000000;
    v.exp[4] = 9'b000100000;
    v.exp[5] = c5;
    v.exp[6] = c6;
    v.exp[7] = c7;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; zero = 1'b0; opcode = 3'd2;
`ifdef STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif

    vecs[0] = mk("ADD",    3'd2, 1'b0, 9'b010000000, 9'b010000000, 9'b010000010);
    vecs[1] = mk("AND_z1", 3'd3, 1'b1, 9'b010000000, 9'b010000000, 9'b010000010);
    vecs[2] = mk("XOR",    3'd4, 1'b0, 9'b010000000, 9'b010000000, 9'b010000010);
    vecs[3] = mk("LDA",    3'd5, 1'b0, 9'b010000000, 9'b010000000, 9'b010000010);
    vecs[4] = mk("STO",    3'd6, 1'b0, 9'b000000000, 9'b000000100, 9'b000000101);
    vecs[5] = mk("SKZ_z1", 3'd1, 1'b1, 9'b000000000, 9'b000100000, 9'b000000000);
    vecs[6] = mk("SKZ_z0", 3'd1, 1'b0, 9'b000000000, 9'b000000000, 9'b000000000);
    vecs[7] = mk("JMP",    3'd7, 1'b1, 9'b000000000, 9'b000001000, 9'b000001000);

    // Reset state, and IDLE ignores everything but start
    tick(2);
    do_reset();
    check("reset_phase", phase, 0);
    check("reset_ctrl", ctrl, 0);
    check("reset_busy", busy, 0);
    check("reset_cnt", instr_cnt, 0);
    tick(3);
    check("idle_hold_busy", busy, 0);

    // Table: one full instruction per opcode from reset
    foreach (vecs[k]) begin
      do_reset();
      opcode = vecs[k].op;
      zero   = vecs[k].z;
      pulse_start();
      for (int p = 0; p < 8; p++) begin
        check($sformatf("%s_phase%0d", vecs[k].name, p), phase, p);
        check($sformatf("%s_ctrl_p%0d", vecs[k].name, p), ctrl, vecs[k].exp[p]);
        check($sformatf("%s_busy_p%0d", vecs[k].name, p), busy, 1);
        check($sformatf("%s_wr_ldir_p%0d", vecs[k].name, p), wr & ld_ir, 0);
        tick();
      end
      check($sformatf("%s_wrap_phase", vecs[k].name), phase, 0);
      check($sformatf("%s_cnt", vecs[k].name), instr_cnt, 1);
    end

    // HLT: halt at phase 4, hold HALTED for 10 cycles, restart at phase 5
    do_reset();
    opcode = 3'd0; zero = 1'b0;
    pulse_start();
    tick(4);
    check("hlt_p4_phase", phase, 4);
    check("hlt_p4_ctrl", ctrl, 9'b000110000);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("halted_phase_c%0d", i), phase, 4);
      check($sformatf("halted_busy_c%0d", i), busy, 0);
      check($sformatf("halted_ctrl_c%0d", i), ctrl, 9'b000010000);
      tick();
    end
    opcode = 3'd2;
    pulse_start();
    check("resume_phase", phase, 5);
    check("resume_busy", busy, 1);
    check("resume_ctrl", ctrl, 9'b010000000);
    pulse_start();  // start in RUN is ignored
    check("run_start_ignored", phase, 6);
    tick(2);
    check("resume_wrap_phase", phase, 0);
    check("resume_wrap_cnt", instr_cnt, 1);

    // Reset mid-JMP at phase 6 after one completed instruction
    do_reset();
    opcode = 3'd7; zero = 1'b0;
    pulse_start();
    tick(8);
    check("jmp_cnt_before", instr_cnt, 1);
    tick(6);
    check("jmp_p6_ctrl", ctrl, 9'b000001000);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("midrst_phase", phase, 0);
    check("midrst_ctrl", ctrl, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", instr_cnt, 0);

    // Counter wraps after 256 instructions
    opcode = 3'd2;
    pulse_start();
    tick(255 * 8);
    check("cnt_255", instr_cnt, 255);
    tick(8);
    check("cnt_256_wrap", instr_cnt, 0);
    check("cnt_256_phase", phase, 0);

`ifdef STEP_EN
    // Single-step: pause after each instruction, step advances exactly one
    do_reset();
    step_mode = 1'b1;
    opcode = 3'd2;
    pulse_start();
    tick(8);
    check("pause_phase", phase, 0);
    check("pause_busy", busy, 0);
    check("pause_ctrl", ctrl, 0);
    check("pause_cnt", instr_cnt, 1);
    tick(3);
    check("pause_hold_cnt", instr_cnt, 1);
    check("pause_hold_busy", busy, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_busy", busy, 1);
    check("step_phase", phase, 0);
    tick(8);
    check("step_cnt", instr_cnt, 2);
    check("step_repause_busy", busy, 0);
    step_mode = 1'b0;
    tick();
    check("unpause_busy", busy, 1);
    check("unpause_phase", phase, 0);
    tick(8);
    check("unpause_cnt", instr_cnt, 3);
    check("unpause_run_busy", busy, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1, run request, one-cycle pulse, sampled in IDLE and HALTED.
REQ-004 SHALL have port zero, input, 1, accumulator-zero flag from datapath.
REQ-005 SHALL have port opcode, input, 3, current IR opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-006 SHALL have port phase, output, 3, registered instruction phase 0..7.
REQ-007 SHALL have outputs sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, each 1 bit: datapath controls.
REQ-008 SHALL have port busy, output, 1, high in RUN state.
REQ-009 SHALL have port instr_cnt, output, 8, completed-instruction count.

Function
REQ-010 SHALL implement states IDLE, RUN, HALTED; PAUSED is added only per REQ-024.
REQ-011 In IDLE, start=1 SHALL set phase=0 and move to RUN next cycle.
REQ-012 In RUN, phase SHALL increment by 1 each cycle and wrap 7->0.
REQ-013 On each 7->0 wrap, instr_cnt SHALL increment, wrapping 255->0.
REQ-014 In RUN, phase=4 with opcode=HLT SHALL move to HALTED next cycle, with phase frozen at 4.
REQ-015 In HALTED, start=1 SHALL return to RUN with phase=5 next cycle; start in RUN SHALL be ignored.
REQ-016 Control outputs SHALL be combinational from registered state, phase, opcode and zero (zero latency); in IDLE all SHALL be 0; in HALTED only halt=1.
REQ-017 Control outputs in RUN SHALL be:
- ALU = opcode in {ADD, AND, XOR, LDA}.
- phase 0: sel.
- phase 1: sel, rd.
- phase 2: sel, rd, ld_ir.
- phase 3: sel, rd, ld_ir.
- phase 4: inc_pc, halt=(opcode==HLT).
- phase 5: rd=ALU.
- phase 6: rd=ALU, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
- phase 7: rd=ALU, ld_pc=(opcode==JMP), data_e=(opcode==STO), ld_ac=ALU, wr=(opcode==STO).
- All other outputs 0.
REQ-018 wr and ld_ir SHALL never be asserted in the same cycle.
REQ-019 busy SHALL equal (state==RUN).

Reset
REQ-020 rst=1 SHALL take priority over start and all other inputs, including mid-instruction.
REQ-021 After reset: state=IDLE, phase=0, instr_cnt=0, and all control outputs and busy 0.

Configuration
REQ-022 Macro STEP_EN SHALL control single-step support.
REQ-023 With STEP_EN defined, the module SHALL add inputs step_mode (1 bit, level) and step (1 bit, pulse).
REQ-024 With STEP_EN defined and step_mode=1 at a 7->0 wrap, the module SHALL enter PAUSED at phase 0 with all outputs 0; step=1 in PAUSED SHALL resume RUN at phase 0 for one instruction; step_mode=0 in PAUSED SHALL resume RUN next cycle.
REQ-025 Without STEP_EN, step_mode, step and PAUSED SHALL not exist, and behaviour SHALL be exactly REQ-010..REQ-019.

Verification
REQ-026 Reset then start pulse, opcode=ADD -> phases 0..7 in order; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; instr_cnt=1 after wrap.
REQ-027 opcode=STO -> data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 in phases 5-7.
REQ-028 opcode=SKZ: with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only.
REQ-029 opcode=HLT -> halt=1 in phase 4; HALTED with phase=4, busy=0 held 10 cycles; start -> phase=5, busy=1 next cycle.
REQ-030 rst=1 asserted at phase 6 of a JMP -> next cycle phase=0, all outputs 0, instr_cnt=0; 256 instructions from reset -> instr_cnt=0.
REQ-031 With STEP_EN and step_mode=1 -> PAUSED after each instruction; each step pulse advances instr_cnt by exactly 1.
